gshare_branch_ctrl: RTL and testbench

- Control stage directly upstream of the pattern history table (PHT); drives its read and write ports.
- Fetch side: forms the gshare index (PC xor speculative global history) and returns the taken/not-taken prediction in the same cycle.
- Each prediction is checkpointed in an in-order FIFO. On resolution the controller computes the saturating counter update, writes it to the PHT, and repairs history on a mispredict.

---
 rtl/gshare_branch_ctrl_pkg.sv | 29 ++
 rtl/gshare_branch_ctrl_ckpt_fifo.sv | 59 +++++
 rtl/gshare_branch_ctrl.sv | 109 ++++++++++
 tb/tb_gshare_branch_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gshare_branch_ctrl_pkg.sv
// Shared types and helpers for the gshare branch controller (package bp_pkg).
// BP_S_INDEX/BP_WIDTH/BP_HIST_LEN describe the default configuration.
package bp_pkg;

  localparam int unsigned BP_S_INDEX  = 10;
  localparam int unsigned BP_WIDTH    = 2;
  localparam int unsigned BP_HIST_LEN = 10;

  localparam logic [BP_WIDTH-1:0] CTR_MIN = '0;
  localparam logic [BP_WIDTH-1:0] CTR_MAX = '1;

  // Checkpoint captured for every accepted prediction (default widths).
  typedef struct packed {
    logic [BP_S_INDEX-1:0]  index;
    logic [BP_WIDTH-1:0]    counter;
    logic                   pred_taken;
    logic [BP_HIST_LEN-1:0] ghr_before;
  } bp_ckpt_t;

  // Saturating counter update for a counter of w bits held in a 32-bit carrier.
  function automatic logic [31:0] sat_update(input logic [31:0] c, input logic taken,
                                             input int unsigned w);
    logic [31:0] cmax;
    cmax = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    if (taken) sat_update = (c >= cmax) ? cmax : c + 32'd1;
    else       sat_update = (c == '0) ? '0 : c - 32'd1;
  endfunction

endpackage

// File: rtl/gshare_branch_ctrl_ckpt_fifo.sv
// bp_ckpt_fifo: in-order checkpoint FIFO with push, pop and flush.
// Flush has priority over push and pop; pointers wrap naturally.
module bp_ckpt_fifo
  import bp_pkg::*;
#(
  parameter int unsigned DW    = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DW-1:0]              din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [DW-1:0]              dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (PW+1)'(DEPTH));
  assign count   = cnt;
  assign dout    = mem[head];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointer and occupancy tracking; flush returns to the empty state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      cnt <= cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Entry storage; a write racing a flush is harmless since the slot is dead.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= din;
  end

endmodule

// File: rtl/gshare_branch_ctrl.sv
// gshare_branch_ctrl: gshare index formation, prediction checkpointing,
// PHT counter update on resolution and history repair on mispredict.
// Optional macro BP_STATS_EN adds stat_preds / stat_mispreds counters.
module gshare_branch_ctrl
  import bp_pkg::*;
#(
  parameter int unsigned S_INDEX  = 10,
  parameter int unsigned WIDTH    = 2,
  parameter int unsigned HIST_LEN = 10,
  parameter int unsigned DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pred_valid,
  input  logic [31:0]        pred_pc,
  output logic               pred_ready,
  output logic               pred_taken,
  input  logic               resolve_valid,
  input  logic               resolve_taken,
  output logic               mispredict,
  output logic [S_INDEX-1:0] pht_rindex,
  input  logic [WIDTH-1:0]   pht_rdata,
  output logic               pht_load,
  output logic [S_INDEX-1:0] pht_windex,
  output logic [WIDTH-1:0]   pht_wdata
`ifdef BP_STATS_EN
  ,
  output logic [31:0]        stat_preds,
  output logic [31:0]        stat_mispreds
`endif
);

  typedef struct packed {
    logic [S_INDEX-1:0]  index;
    logic [WIDTH-1:0]    counter;
    logic                pred_taken;
    logic [HIST_LEN-1:0] ghr_before;
  } ckpt_t;

  logic [HIST_LEN-1:0]    ghr;
  logic [S_INDEX-1:0]     idx;
  ckpt_t                  push_ck;
  ckpt_t                  head;
  logic                   empty;
  logic                   full;
  logic [$clog2(DEPTH):0] count;
  logic                   res_fire;
  logic                   pred_fire;
  logic                   unused_ok;

  assign unused_ok = ^{pred_pc[31:S_INDEX+2], pred_pc[1:0], count};

  assign idx        = pred_pc[S_INDEX+1:2] ^ S_INDEX'(ghr);
  assign pht_rindex = idx;
  assign pred_taken = pht_rdata[WIDTH-1];
  assign pred_ready = ~full;

  // rst gates the resolve path so nothing is written while reset is held.
  assign res_fire   = rst & resolve_valid & ~empty;
  assign mispredict = res_fire & (resolve_taken != head.pred_taken);
  assign pred_fire  = pred_valid & pred_ready & ~mispredict;

  assign pht_load   = res_fire;
  assign pht_windex = head.index;
  assign pht_wdata  = WIDTH'(sat_update(32'(head.counter), resolve_taken, WIDTH));

  assign push_ck = '{index: idx, counter: pht_rdata, pred_taken: pred_taken, ghr_before: ghr};

  bp_ckpt_fifo #(
    .DW    ($bits(ckpt_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pred_fire),
    .din   (push_ck),
    .pop   (res_fire & ~mispredict),
    .flush (mispredict),
    .dout  (head),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  // Speculative history: repaired from the head checkpoint on mispredict, else shifted per prediction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ghr <= '0;
    end else if (mispredict) begin
      ghr <= {head.ghr_before[HIST_LEN-2:0], resolve_taken};
    end else if (pred_fire) begin
      ghr <= {ghr[HIST_LEN-2:0], pred_taken};
    end
  end

`ifdef BP_STATS_EN
  // Resolution and mispredict event counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_preds    <= '0;
      stat_mispreds <= '0;
    end else begin
      if (res_fire)   stat_preds    <= stat_preds + 32'd1;
      if (mispredict) stat_mispreds <= stat_mispreds + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gshare_branch_ctrl.sv
module tb_gshare_branch_ctrl;
  import bp_pkg::*;

  logic        clk;
  logic        rst;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_ready;
  logic        pred_taken;
  logic        resolve_valid;
  logic        resolve_taken;
  logic        mispredict;
  logic [9:0]  pht_rindex;
  logic [1:0]  pht_rdata;
  logic        pht_load;
  logic [9:0]  pht_windex;
  logic [1:0]  pht_wdata;
`ifdef BP_STATS_EN
  logic [31:0] stat_preds;
  logic [31:0] stat_mispreds;
  int unsigned m_sp, m_sm;
`endif

  logic [1:0] pht_mem [1024];
  assign pht_rdata = pht_mem[pht_rindex];

  gshare_branch_ctrl #(
    .S_INDEX  (10),
    .WIDTH    (2),
    .HIST_LEN (10),
    .DEPTH    (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pred_valid    (pred_valid),
    .pred_pc       (pred_pc),
    .pred_ready    (pred_ready),
    .pred_taken    (pred_taken),
    .resolve_valid (resolve_valid),
    .resolve_taken (resolve_taken),
    .mispredict    (mispredict),
    .pht_rindex    (pht_rindex),
    .pht_rdata     (pht_rdata),
    .pht_load      (pht_load),
    .pht_windex    (pht_windex),
    .pht_wdata     (pht_wdata)
`ifdef BP_STATS_EN
    ,
    .stat_preds    (stat_preds),
    .stat_mispreds (stat_mispreds)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: queue of outstanding checkpoints plus architectural history.
  bp_ckpt_t   q[$];
  logic [9:0] ghr_m;
  logic [9:0] e_idx;
  logic       e_taken, e_ready, e_hit, e_mis;
  logic       c_pv, c_rt, c_rn;
  logic       w_ld;
  logic [9:0] w_i;
  logic [1:0] w_d;

  function automatic int unsigned upd(input int unsigned c, input logic taken);
    if (taken) return (c < int'(CTR_MAX)) ? c + 1 : int'(CTR_MAX);
    return (c > int'(CTR_MIN)) ? c - 1 : int'(CTR_MIN);
  endfunction

  task automatic cyc(input logic pv, input logic [31:0] pc, input logic rv,
                     input logic rt, input logic rn);
    @(negedge clk);
    rst = rn; pred_valid = pv; pred_pc = pc; resolve_valid = rv; resolve_taken = rt;
    c_pv = pv; c_rt = rt; c_rn = rn;
    #1;
    e_idx   = pc[11:2] ^ ghr_m;
    e_taken = pht_mem[e_idx][1];
    e_ready = (q.size() != 4);
    e_hit   = rn && rv && (q.size() > 0);
    e_mis   = e_hit && (rt != q[0].pred_taken);
    check("rindex", 32'(pht_rindex), 32'(e_idx));
    check("pred_taken", 32'(pred_taken), 32'(e_taken));
    check("pred_ready", 32'(pred_ready), 32'(e_ready));
    check("mispredict", 32'(mispredict), 32'(e_mis));
    check("pht_load", 32'(pht_load), 32'(e_hit));
    if (e_hit) begin
      check("pht_windex", 32'(pht_windex), 32'(q[0].index));
      check("pht_wdata", 32'(pht_wdata), upd(32'(q[0].counter), rt));
    end
`ifdef BP_STATS_EN
    check("stat_preds", stat_preds, m_sp);
    check("stat_mispreds", stat_mispreds, m_sm);
`endif
    w_ld = pht_load; w_i = pht_windex; w_d = pht_wdata;
  endtask

  task automatic adv();
    bp_ckpt_t ck;
    if (!c_rn) begin
      q.delete();
      ghr_m = '0;
`ifdef BP_STATS_EN
      m_sp = 0; m_sm = 0;
`endif
    end else if (e_mis) begin
      ghr_m = {q[0].ghr_before[8:0], c_rt};
      q.delete();
`ifdef BP_STATS_EN
      m_sp++; m_sm++;
`endif
    end else begin
      if (e_hit) begin
        void'(q.pop_front());
`ifdef BP_STATS_EN
        m_sp++;
`endif
      end
      if (c_pv && e_ready) begin
        ck.index = e_idx; ck.counter = pht_mem[e_idx]; ck.pred_taken = e_taken;
        ck.ghr_before = ghr_m;
        q.push_back(ck);
        ghr_m = {ghr_m[8:0], e_taken};
      end
    end
    @(posedge clk);
    if (w_ld) pht_mem[w_i] = w_d;
  endtask

  task automatic run(input logic pv, input logic [31:0] pc, input logic rv,
                     input logic rt, input logic rn);
    cyc(pv, pc, rv, rt, rn);
    adv();
  endtask

  task automatic set_pht(input logic [31:0] pc, input logic [1:0] v);
    logic [9:0] i;
    i = pc[11:2] ^ ghr_m;
    pht_mem[i] = v;
  endtask

  initial begin
    logic pv, rv, rt, rn;
    logic [31:0] pc;
    for (int i = 0; i < 1024; i++) pht_mem[i] = 2'b10;
    rst = 1'b0; pred_valid = 1'b0; pred_pc = '0; resolve_valid = 1'b0; resolve_taken = 1'b0;
    ghr_m = '0;
`ifdef BP_STATS_EN
    m_sp = 0; m_sm = 0;
`endif
    run(0, 0, 0, 0, 0);
    run(0, 0, 0, 0, 0);

    // First prediction from reset: index 0, weakly taken.
    cyc(1, 32'h0, 0, 0, 1);
    check("d_rindex0", 32'(pht_rindex), 32'h0);
    check("d_taken0", 32'(pred_taken), 32'h1);
    check("d_ready0", 32'(pred_ready), 32'h1);
    adv();
    // Correct taken resolve: 10 -> 11.
    cyc(0, 0, 1, 1, 1);
    check("d_load1", 32'(pht_load), 32'h1);
    check("d_wdata1", 32'(pht_wdata), 32'h3);
    check("d_mis1", 32'(mispredict), 32'h0);
    adv();
    // History bit0 now set, so pc 0 maps to index 1.
    cyc(1, 32'h0, 0, 0, 1);
    check("d_rindex_ghr", 32'(pht_rindex), 32'h1);
    adv();
    set_pht(32'h0, 2'b11);
    run(1, 32'h0, 0, 0, 1);
    run(0, 0, 1, 1, 1);
    cyc(0, 0, 1, 1, 1);
    check("d_wdata_sat", 32'(pht_wdata), 32'h3);
    adv();
    // Weakly not-taken counter, resolved taken: mispredict and repair.
    set_pht(32'h0, 2'b01);
    cyc(1, 32'h0, 0, 0, 1);
    check("d_taken_nt", 32'(pred_taken), 32'h0);
    adv();
    cyc(0, 0, 1, 1, 1);
    check("d_mis", 32'(mispredict), 32'h1);
    check("d_wdata_mis", 32'(pht_wdata), 32'h2);
    adv();
    cyc(0, 0, 1, 0, 1);
    check("d_empty_load", 32'(pht_load), 32'h0);
    adv();
    // Fill to capacity; fifth request must be refused.
    for (int i = 0; i < 4; i++) run(1, 32'(i * 4), 0, 0, 1);
    cyc(1, 32'h100, 0, 0, 1);
    check("d_full", 32'(pred_ready), 32'h0);
    adv();
    run(0, 0, 1, q[0].pred_taken, 1);
    cyc(0, 0, 0, 0, 1);
    check("d_ready_again", 32'(pred_ready), 32'h1);
    adv();
    // Prediction in the same cycle as a mispredict is dropped.
    cyc(1, 32'h200, 1, ~q[0].pred_taken, 1);
    check("d_mis_drop", 32'(mispredict), 32'h1);
    adv();
    cyc(0, 0, 1, 0, 1);
    check("d_drop_empty", 32'(pht_load), 32'h0);
    adv();
    // Reset with three entries in flight.
    for (int i = 0; i < 3; i++) run(1, 32'(i * 8), 0, 0, 1);
    cyc(0, 0, 1, 1, 0);
    check("d_rst_load", 32'(pht_load), 32'h0);
    check("d_rst_mis", 32'(mispredict), 32'h0);
    adv();
    cyc(1, 32'h40, 1, 1, 1);
    check("d_post_rst_load", 32'(pht_load), 32'h0);
    check("d_post_rst_idx", 32'(pht_rindex), 32'h10);
    adv();

    // Randomized traffic against the model.
    for (int i = 0; i < 1024; i++) pht_mem[i] = 2'($urandom);
    for (int n = 0; n < 3000; n++) begin
      rn = ($urandom_range(0, 199) != 0);
      pv = ($urandom_range(0, 9) < 7);
      rv = ($urandom_range(0, 1) == 1);
      pc = (n % 5 == 0) ? $urandom_range(0, 15) * 4 : $urandom;
      if (q.size() > 0 && $urandom_range(0, 3) != 0) rt = q[0].pred_taken;
      else rt = 1'($urandom);
      run(pv, pc, rv, rt, rn);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
